// File: rtl/mem_stage_pkg.sv
// Shared core definitions: default datapath widths used by every pipeline stage,
// plus the memory-stage state encoding.
package mem_stage_pkg;

    localparam int CORE_ADDR_W = 16;
    localparam int CORE_DATA_W = 32;
    localparam int CORE_REG_W  = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } stage_state_e;

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores to a single-port synchronous
// data memory and produces the write-back triple, stalling upstream for one cycle per load.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = CORE_ADDR_W,
    parameter int DATA_W = CORE_DATA_W,
    parameter int REG_W  = CORE_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              ld_i,
    input  logic              st_i,
    input  logic              wb_en_i,
    input  logic [REG_W-1:0]  rd_addr_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic              stall_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_w_o,
    output logic [DATA_W-1:0] mem_d_o,
    input  logic [DATA_W-1:0] mem_q_i,
    output logic              wb_en_o,
    output logic [REG_W-1:0]  rd_addr_o,
    output logic [DATA_W-1:0] wb_data_o
);

    stage_state_e      state;
    logic [ADDR_W-1:0] ld_addr;
    logic [REG_W-1:0]  ld_rd;
    logic              in_ld_wait;
    logic              consume;

    assign in_ld_wait = (state == LD_WAIT);

    // Reset is the only input allowed to gate stall/write, so neither leaks out while rst is high.
    assign stall_o = in_ld_wait && !rst;
    assign consume = valid_i && !in_ld_wait;
    assign mem_w_o = consume && st_i && !rst;
    assign mem_a_o = in_ld_wait ? ld_addr : result_i[ADDR_W-1:0];
    assign mem_d_o = st_data_i;

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking would let later statements see already-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wb_en_o   <= 1'b0;
            rd_addr_o <= '0;
            wb_data_o <= '0;
            ld_addr   <= '0;
            ld_rd     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!consume) begin
                        wb_en_o <= 1'b0;
                    end else if (st_i) begin
                        wb_en_o <= 1'b0;
                    end else if (ld_i) begin
                        ld_addr <= result_i[ADDR_W-1:0];
                        ld_rd   <= rd_addr_i;
                        wb_en_o <= 1'b0;
                        state   <= LD_WAIT;
                    end else begin
                        wb_en_o   <= wb_en_i;
                        rd_addr_o <= rd_addr_i;
                        wb_data_o <= result_i;
                    end
                end
                LD_WAIT: begin
                    // Memory has registered the read at the accept edge; retire it now.
                    wb_en_o   <= 1'b1;
                    rd_addr_o <= ld_rd;
                    wb_data_o <= mem_q_i;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: behavioural data memory, architectural
// reference model with a write-back schedule, directed scenarios plus random ops.
module tb_mem_stage;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    typedef struct {
        bit          valid;
        bit          ld;
        bit          st;
        bit          wb_en;
        logic [3:0]  rd;
        logic [31:0] result;
        logic [31:0] sdata;
    } op_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i, ld_i, st_i, wb_en_i;
    logic [REG_W-1:0]  rd_addr_i;
    logic [DATA_W-1:0] result_i, st_data_i;
    logic              stall_o, mem_w_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic [DATA_W-1:0] mem_d_o, mem_q_i;
    logic              wb_en_o;
    logic [REG_W-1:0]  rd_addr_o;
    logic [DATA_W-1:0] wb_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ld_i(ld_i), .st_i(st_i),
        .wb_en_i(wb_en_i), .rd_addr_i(rd_addr_i), .result_i(result_i),
        .st_data_i(st_data_i), .stall_o(stall_o), .mem_a_o(mem_a_o),
        .mem_w_o(mem_w_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i),
        .wb_en_o(wb_en_o), .rd_addr_o(rd_addr_o), .wb_data_o(wb_data_o)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, registered read.
    logic [31:0] dmem [65536];
    always @(posedge clk) begin
        if (mem_w_o) dmem[mem_a_o] <= mem_d_o;
        mem_q_i <= dmem[mem_a_o];
    end

    // Architectural reference state.
    logic [31:0] ref_mem [int];
    bit          m_pend;
    logic [15:0] m_addr;
    logic [3:0]  m_rd;
    bit          e_en, e_known;
    logic [3:0]  e_rd;
    logic [31:0] e_data;

    function automatic logic [31:0] init_val(int a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(int'(a));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input op_t op);
        valid_i   = op.valid;
        ld_i      = op.ld;
        st_i      = op.st;
        wb_en_i   = op.wb_en;
        rd_addr_i = op.rd;
        result_i  = op.result;
        st_data_i = op.sdata;
    endtask

    // One clock cycle: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle(input op_t op, output bit consumed);
        logic [15:0] a;
        a = op.result[15:0];
        drive(op);
        #1;
        check("stall", 32'(stall_o), 32'(m_pend));
        check("mem_w", 32'(mem_w_o), 32'(op.valid && op.st && !m_pend));
        check("mem_a", 32'(mem_a_o), 32'(m_pend ? m_addr : a));
        check("mem_d", mem_d_o, op.sdata);
        consumed = op.valid && !m_pend;
        if (m_pend) begin
            m_pend = 0; e_en = 1; e_rd = m_rd; e_data = ref_rd(m_addr); e_known = 1;
        end else if (consumed && op.st) begin
            ref_mem[int'(a)] = op.sdata; e_en = 0; e_known = 0;
        end else if (consumed && op.ld) begin
            m_pend = 1; m_addr = a; m_rd = op.rd; e_en = 0; e_known = 0;
        end else if (consumed) begin
            e_en = op.wb_en; e_rd = op.rd; e_data = op.result; e_known = 1;
        end else begin
            e_en = 0;
        end
        @(posedge clk);
        #1;
        check("wb_en", 32'(wb_en_o), 32'(e_en));
        if (e_known) begin
            check("rd_addr", 32'(rd_addr_o), 32'(e_rd));
            check("wb_data", wb_data_o, e_data);
        end
    endtask

    // Present an op until consumed, as upstream would; bounded.
    task automatic run_op(input op_t op);
        bit c;
        c = 0;
        for (int i = 0; i < 3 && !c; i++) cycle(op, c);
        if (!c) check("consume_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input op_t op);
        rst = 1'b1;
        drive(op);
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_mem_w", 32'(mem_w_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_pend = 0; e_en = 0; e_rd = 0; e_data = 0; e_known = 1;
        check("rst_wb_en", 32'(wb_en_o), 32'd0);
        check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_stall_after", 32'(stall_o), 32'd0);
    endtask

    function automatic op_t mk(bit v, bit l, bit s, bit w, logic [3:0] rd,
                               logic [31:0] res, logic [31:0] sd);
        op_t o;
        o.valid = v; o.ld = l; o.st = s; o.wb_en = w; o.rd = rd; o.result = res; o.sdata = sd;
        return o;
    endfunction

    initial begin
        op_t nop, o;
        bit  c;
        int  kind;
        for (int i = 0; i < 65536; i++) dmem[i] = init_val(i);
        nop = mk(0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
        drive(nop);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset(nop);

        // ALU op, latency 1.
        run_op(mk(1, 0, 0, 1, 4'd3, 32'h0000_1234, 32'd0));
        // Store then load to the same address.
        run_op(mk(1, 0, 1, 1, 4'd1, 32'h0000_0010, 32'hDEAD_BEEF));
        run_op(mk(1, 1, 0, 1, 4'd5, 32'h0000_0010, 32'd0));
        cycle(nop, c);
        check("st_ld_data", wb_data_o, 32'hDEAD_BEEF);
        // Load immediately followed by ALU op: ALU op is held one cycle.
        run_op(mk(1, 1, 0, 1, 4'd2, 32'h0000_0010, 32'd0));
        run_op(mk(1, 0, 0, 1, 4'd7, 32'h0000_0055, 32'd0));
        cycle(nop, c);
        // Address wrap.
        drive(mk(1, 0, 1, 0, 4'd0, 32'h0001_0004, 32'hCAFE_F00D));
        #1;
        check("wrap_mem_a", 32'(mem_a_o), 32'h0000_0004);
        run_op(mk(1, 0, 1, 0, 4'd0, 32'h0001_0004, 32'hCAFE_F00D));
        run_op(mk(1, 1, 0, 1, 4'd9, 32'h0000_0004, 32'd0));
        cycle(nop, c);
        check("wrap_ld_data", wb_data_o, 32'hCAFE_F00D);
        // ld and st together: store priority.
        run_op(mk(1, 1, 1, 1, 4'd6, 32'h0000_0020, 32'h1357_9BDF));
        // Reset while waiting on a load; a store presented during reset must not write.
        run_op(mk(1, 1, 0, 1, 4'd4, 32'h0000_0020, 32'd0));
        do_reset(mk(1, 0, 1, 0, 4'd0, 32'h0000_0030, 32'h0BAD_0BAD));
        run_op(mk(1, 0, 0, 1, 4'd8, 32'h0000_00AA, 32'd0));
        run_op(mk(1, 1, 0, 1, 4'd8, 32'h0000_0030, 32'd0));
        cycle(nop, c);

        // Random ops over a small address pool with random upper bits.
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            o = mk($urandom_range(0, 9) != 0, kind inside {[4:6], 9}, kind inside {[7:9]},
                   1'($urandom), 4'($urandom), ($urandom & 32'hFFFF_0000) | $urandom_range(0, 7),
                   $urandom);
            if (o.valid) run_op(o);
            else cycle(o, c);
        end
        cycle(nop, c);
        cycle(nop, c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
